// File: rtl/stim_pkg.sv
// Shared types and the 16-bit Galois LFSR step used by the stimulus sequencer and its MISR.
package stim_pkg;

    localparam int          LFSR_W       = 16;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        HOLD,
        DONE
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/stim_lfsr_driver_if.sv
// Valid/ready stimulus channel between the LFSR sequencer (master) and its consumer (slave).
interface stim_lfsr_driver_if #(
    parameter int NUM_INPUTS = 6
);
    logic [NUM_INPUTS-1:0] vec;
    logic                  vec_valid;
    logic                  vec_ready;

    modport master (output vec, output vec_valid, input vec_ready);
    modport slave  (input vec, input vec_valid, output vec_ready);
endinterface

// File: rtl/stim_hold_counter.sv
// Loadable down-counter with zero flag; times the idle gap between stimulus vectors.
module stim_hold_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] value,
    output logic         zero
);
    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/stim_lfsr_driver.sv
// Seeded LFSR stimulus sequencer: offers N_VECTORS vectors over valid/ready with a hold gap.
// Optional response MISR (rsp/signature ports) enabled by STIM_LFSR_DRIVER_SIGNATURE_EN.
module stim_lfsr_driver
    import stim_pkg::*;
#(
    parameter int          NUM_INPUTS  = 6,
    parameter int          N_VECTORS   = 20,
    parameter int          HOLD_CYCLES = 10,
    parameter logic [15:0] SEED        = DEFAULT_SEED
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               abort,
    stim_lfsr_driver_if.master                 bus,
    output logic [$clog2(N_VECTORS+1)-1:0]     vec_idx,
    output logic                               busy,
    output logic                               done
`ifdef STIM_LFSR_DRIVER_SIGNATURE_EN
    ,
    input  logic [7:0]                         rsp,
    output logic [15:0]                        signature
`endif
);
    localparam int IDX_W = $clog2(N_VECTORS + 1);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [15:0]      SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(N_VECTORS);

    state_t      state;
    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;
    logic [15:0] seed_nxt;
    logic        hs;
    logic        last_vec;
    logic        start_go;
    logic        hold_load;
    logic        hold_zero;

    assign lfsr_nxt  = lfsr_step(lfsr);
    assign seed_nxt  = lfsr_step(SEED_EFF);
    assign hs        = bus.vec_valid && bus.vec_ready;
    assign last_vec  = (32'(vec_idx) + 32'd1) == 32'(N_VECTORS);
    assign start_go  = ((state == IDLE) || (state == DONE)) && start && !abort;
    assign hold_load = (state == DRIVE) && hs && !abort && !last_vec && (HOLD_CYCLES != 0);

    // Loaded with HOLD_CYCLES-1 on the handshake so HOLD lasts exactly HOLD_CYCLES cycles.
    stim_hold_counter #(.W(CNT_W)) u_hold (
        .clk   (clk),
        .rst   (rst),
        .load  (hold_load),
        .en    (state == HOLD),
        .value (HOLD_LOAD),
        .zero  (hold_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            lfsr          <= SEED_EFF;
            bus.vec       <= '0;
            bus.vec_valid <= 1'b0;
            vec_idx       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else if (abort) begin
            state         <= IDLE;
            bus.vec_valid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        lfsr          <= seed_nxt;
                        bus.vec       <= seed_nxt[NUM_INPUTS-1:0];
                        bus.vec_valid <= 1'b1;
                        vec_idx       <= '0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        state         <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (hs) begin
                        if (vec_idx != IDX_MAX) vec_idx <= vec_idx + 1'b1;
                        if (last_vec) begin
                            bus.vec_valid <= 1'b0;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            state         <= DONE;
                        end else if (HOLD_CYCLES == 0) begin
                            lfsr    <= lfsr_nxt;
                            bus.vec <= lfsr_nxt[NUM_INPUTS-1:0];
                        end else begin
                            bus.vec_valid <= 1'b0;
                            state         <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (hold_zero) begin
                        lfsr          <= lfsr_nxt;
                        bus.vec       <= lfsr_nxt[NUM_INPUTS-1:0];
                        bus.vec_valid <= 1'b1;
                        state         <= DRIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef STIM_LFSR_DRIVER_SIGNATURE_EN
    logic        hs_d;
    logic [15:0] sig;

    // The response for a vector is sampled one cycle after its handshake, even if that lands in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_d <= 1'b0;
            sig  <= '0;
        end else if (start_go) begin
            hs_d <= 1'b0;
            sig  <= '0;
        end else begin
            hs_d <= (state == DRIVE) && hs && !abort;
            if (hs_d) sig <= lfsr_step(sig) ^ {8'h00, rsp};
        end
    end

    assign signature = sig;
`else
    logic unused_start_go;
    assign unused_start_go = start_go;
`endif

endmodule

// File: tb/tb_stim_lfsr_driver.sv
// Self-checking bench for stim_lfsr_driver: default and back-to-back instances vs. a transaction-level model.
module tb_stim_lfsr_driver;
    localparam int NV   = 20;
    localparam int HOLD = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort, start0;
    logic [4:0] vec_idx, vec_idx0;
    logic       busy, done, busy0, done0;

    stim_lfsr_driver_if #(.NUM_INPUTS(6)) bus ();
    stim_lfsr_driver_if #(.NUM_INPUTS(6)) bus0 ();

`ifdef STIM_LFSR_DRIVER_SIGNATURE_EN
    logic [7:0]  rsp;
    logic [15:0] signature, signature0;
    assign rsp = {7'b0, bus.vec[0]};
`endif

    stim_lfsr_driver #(.NUM_INPUTS(6), .N_VECTORS(NV), .HOLD_CYCLES(HOLD), .SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .bus(bus),
        .vec_idx(vec_idx), .busy(busy), .done(done)
`ifdef STIM_LFSR_DRIVER_SIGNATURE_EN
        , .rsp(rsp), .signature(signature)
`endif
    );

    stim_lfsr_driver #(.NUM_INPUTS(6), .N_VECTORS(NV), .HOLD_CYCLES(0), .SEED(16'hACE1)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(1'b0), .bus(bus0),
        .vec_idx(vec_idx0), .busy(busy0), .done(done0)
`ifdef STIM_LFSR_DRIVER_SIGNATURE_EN
        , .rsp(8'h00), .signature(signature0)
`endif
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [5:0]  exp_vec [NV];
    logic [15:0] exp_sig;

    function automatic logic [15:0] ref_next(input logic [15:0] s);
        return (s / 16'd2) ^ (((s % 16'd2) == 16'd1) ? 16'hB400 : 16'h0000);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // Accept n vectors from the default instance; optional random backpressure and a start pulse while busy.
    task automatic run_vectors(input int n, input bit rand_ready, input int spurious_k);
        for (int k = 0; k < n; k++) begin
            int         gap;
            int         stall;
            bit         stable;
            logic [5:0] held;
            gap = 0;
            while (!bus.vec_valid && gap < 200) begin
                gap++;
                cyc();
            end
            check($sformatf("valid_seen%0d", k), 32'(bus.vec_valid), 32'd1);
            if (k == 0) check("latency", 32'(gap), 32'd0);
            else        check($sformatf("gap%0d", k), 32'(gap), 32'(HOLD));
            check($sformatf("vec%0d", k), 32'(bus.vec), 32'(exp_vec[k]));
            check($sformatf("idx%0d", k), 32'(vec_idx), 32'(k));
            held   = bus.vec;
            stall  = 0;
            stable = 1'b1;
            while (rand_ready && ($urandom_range(0, 2) == 0) && stall < 8) begin
                bus.vec_ready = 1'b0;
                cyc();
                stall++;
                if (bus.vec !== held || bus.vec_valid !== 1'b1 || vec_idx !== 5'(k)) stable = 1'b0;
            end
            if (rand_ready) check($sformatf("stable%0d", k), 32'(stable), 32'd1);
            bus.vec_ready = 1'b1;
            if (k == spurious_k) start = 1'b1;
            cyc();
            start = 1'b0;
        end
        if (n == NV) begin
            check("end_done",  32'(done), 32'd1);
            check("end_idx",   32'(vec_idx), 32'(NV));
            check("end_valid", 32'(bus.vec_valid), 32'd0);
            check("end_busy",  32'(busy), 32'd0);
            check("end_vec",   32'(bus.vec), 32'(exp_vec[NV-1]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] s;
        s = 16'hACE1;
        exp_sig = 16'h0000;
        for (int k = 0; k < NV; k++) begin
            s          = ref_next(s);
            exp_vec[k] = s[5:0];
            exp_sig    = ref_next(exp_sig) ^ {15'b0, exp_vec[k][0]};
        end

        rst = 1'b1; start = 1'b0; abort = 1'b0; start0 = 1'b0;
        bus.vec_ready = 1'b0; bus0.vec_ready = 1'b0;
        cyc();
        check("rst_vec",   32'(bus.vec), 32'd0);
        check("rst_valid", 32'(bus.vec_valid), 32'd0);
        check("rst_idx",   32'(vec_idx), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        #3 rst = 1'b0;
        repeat (3) cyc();

        // Fixed-ready run
        bus.vec_ready = 1'b1;
        pulse_start();
        check("first_vec", 32'(bus.vec), 32'h30);
        run_vectors(NV, 1'b0, -1);
`ifdef STIM_LFSR_DRIVER_SIGNATURE_EN
        cyc();
        check("signature", 32'(signature), 32'(exp_sig));
`endif

        // Restart from DONE with random backpressure and a start pulse while busy
        pulse_start();
`ifdef STIM_LFSR_DRIVER_SIGNATURE_EN
        check("sig_cleared", 32'(signature), 32'd0);
`endif
        run_vectors(NV, 1'b1, 2);
`ifdef STIM_LFSR_DRIVER_SIGNATURE_EN
        cyc();
        check("signature_rerun", 32'(signature), 32'(exp_sig));
`endif

        // Seven cycles of backpressure on the first vector
        bus.vec_ready = 1'b0;
        pulse_start();
        begin
            bit ok;
            ok = 1'b1;
            for (int i = 0; i < 7; i++) begin
                cyc();
                if (bus.vec !== 6'h30 || vec_idx !== 5'd0 || bus.vec_valid !== 1'b1) ok = 1'b0;
            end
            check("bp_stable", 32'(ok), 32'd1);
        end
        bus.vec_ready = 1'b1;
        cyc();
        bus.vec_ready = 1'b0;
        check("bp_idx",   32'(vec_idx), 32'd1);
        check("bp_valid", 32'(bus.vec_valid), 32'd0);

        // Abort in HOLD after three vectors
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        pulse_start();
        run_vectors(3, 1'b0, -1);
        check("hold_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("abort_busy",  32'(busy), 32'd0);
        check("abort_done",  32'(done), 32'd0);
        check("abort_valid", 32'(bus.vec_valid), 32'd0);
        check("abort_idx",   32'(vec_idx), 32'd3);
        repeat (12) cyc();
        check("abort_idx_kept", 32'(vec_idx), 32'd3);
        bus.vec_ready = 1'b0;
        pulse_start();
        check("restart_vec", 32'(bus.vec), 32'h30);
        check("restart_idx", 32'(vec_idx), 32'd0);

        // Asynchronous reset between clock edges while a vector is offered
        #3 rst = 1'b1;
        #1;
        check("arst_valid", 32'(bus.vec_valid), 32'd0);
        check("arst_vec",   32'(bus.vec), 32'd0);
        check("arst_busy",  32'(busy), 32'd0);
        check("arst_idx",   32'(vec_idx), 32'd0);
        #2 rst = 1'b0;
        cyc();

        // Back-to-back instance
        bus0.vec_ready = 1'b1;
        start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        for (int k = 0; k < NV; k++) begin
            check($sformatf("b2b_valid%0d", k), 32'(bus0.vec_valid), 32'd1);
            check($sformatf("b2b_vec%0d", k), 32'(bus0.vec), 32'(exp_vec[k]));
            cyc();
        end
        check("b2b_done",  32'(done0), 32'd1);
        check("b2b_idx",   32'(vec_idx0), 32'(NV));
        check("b2b_valid", 32'(bus0.vec_valid), 32'd0);
        check("b2b_busy",  32'(busy0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/stim_lfsr_driver.md
Name: stim_lfsr_driver

Overview:
- Upstream stimulus source for combinational DUTs such as the 4:1 mux (inputs a,b,c,d,s0,s1).
- Replaces per-input `$random` plus fixed `#10` delays with a synthesizable, seeded LFSR sequencer.
- Emits N_VECTORS packed input vectors over a valid/ready handshake, with a programmable hold gap between vectors.
- Reports progress (vector index, busy, done).

Parameters:
- NUM_INPUTS, 6, width of the packed vector driven to the DUT (bit0=a … bit5=s1); legal range 1..16.
- N_VECTORS, 20, vectors per run; legal range ≥1.
- HOLD_CYCLES, 10, idle cycles after each accepted vector before the next is offered; 0 means back-to-back.
- SEED, 16'hACE1, LFSR load value; 0 is replaced by 16'h0001.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a run; honoured only in IDLE or DONE.
- abort  in  1  synchronous abort that returns the block to IDLE.
- vec  out  NUM_INPUTS  current stimulus vector.
- vec_valid  out  1  vec is offered to the consumer.
- vec_ready  in  1  consumer accepts vec.
- vec_idx  out  $clog2(N_VECTORS+1)  count of vectors accepted so far.
- busy  out  1  high in DRIVE or HOLD.
- done  out  1  high in DONE.

Behaviour:
- Reset values: async reset puts the FSM in IDLE; vec=0, vec_valid=0, vec_idx=0, busy=0, done=0; LFSR=SEED (0 mapped to 1).
- LFSR: 16-bit Galois, right shift, tap mask 16'hB400.
  - step(s) = (s>>1) ^ (s[0] ? 16'hB400 : 0).
  - vec = step result [NUM_INPUTS-1:0].
  - The state can never reach 0.
- FSM states: IDLE, DRIVE, HOLD, DONE.
- IDLE/DONE + start (cycle t):
  - LFSR <= step(SEED); vec <= low bits of that value; vec_idx <= 0.
  - vec_valid=1 from cycle t+1. Latency start→first valid is 1 cycle.
  - done clears at t+1.
- DRIVE:
  - vec and vec_valid are held stable until vec_valid && vec_ready; ready may toggle freely while waiting.
  - On the handshake vec_idx increments, then:
    - if vec_idx+1 == N_VECTORS → DONE, vec_valid=0, vec keeps its last value.
    - else if HOLD_CYCLES == 0 → LFSR steps, vec updates, vec_valid stays 1, state stays DRIVE.
    - else → HOLD, vec_valid=0, hold counter = HOLD_CYCLES-1.
- HOLD:
  - The counter decrements each cycle.
  - When the counter is 0: LFSR steps, vec updates, state → DRIVE with vec_valid=1 on the next cycle.
  - The total gap between the handshake cycle and the next valid cycle is exactly HOLD_CYCLES cycles of vec_valid=0.
- DONE: done=1 as a level; start restarts the run from SEED, so runs are reproducible.
- start while busy: ignored.
- abort has priority over start and over the handshake:
  - next cycle: IDLE, vec_valid=0, busy=0, done=0.
  - vec_idx is retained until the next start.
- Reset mid-run: immediate async return to reset values; any in-flight vector is dropped.
- vec_idx saturates at N_VECTORS; no wrap.

Optional Feature:
- Macro: STIM_LFSR_DRIVER_SIGNATURE_EN.
- Defined:
  - Adds ports rsp (in, 8 bits, zero-extended DUT outputs) and signature (out, 16 bits).
  - A 16-bit MISR samples rsp on the cycle after each handshake: sig <= step(sig) ^ {8'h0, rsp}.
  - sig clears to 0 on reset and on start; it is frozen in DONE/IDLE.
  - The bench compares signature against a golden value.
- Undefined: no rsp/signature ports and no MISR logic; all other behaviour is identical.

Decomposition:
- Package stim_pkg:
  - state enum {IDLE, DRIVE, HOLD, DONE}
  - LFSR_W=16
  - LFSR_TAPS=16'hB400
  - DEFAULT_SEED=16'hACE1
  - function lfsr_step; the MISR reuses it.
- One sub-module, stim_hold_counter: down-counter with load and zero flag, used for the HOLD gap.
- The LFSR stays inline via the package function.

Test Plan:
- Defaults, vec_ready tied 1: start at cycle 5 → vec_valid at cycle 6 with vec=6'h30, next vector 6'h38 after exactly 10 invalid cycles; done after 20 handshakes, vec_idx=20.
- HOLD_CYCLES=0, ready=1: vec_valid held high for 20 consecutive cycles with a new vec each cycle, then DONE.
- Backpressure: ready low 7 cycles while valid → vec stable at 6'h30, vec_idx stays 0; one handshake when ready rises.
- abort asserted in HOLD after 3 vectors → IDLE next cycle, vec_idx=3; a new start reproduces vec=6'h30 first.
- Async rst pulse mid-DRIVE (between clock edges) → outputs zero immediately; start ignored while busy; start in DONE restarts the identical sequence.
- SIGNATURE_EN with rsp=vec[0] fed back → signature matches the golden value from the reference model for 20 vectors; it resets to 0 on start.
